// File: rtl/cgra_loader_pkg.sv
// Shared state/mode types and parameter defaults for the CGRA config stream loader.
// The optional pad-observation signature is enabled by defining CGRA_LOADER_CAPTURE_EN.
package cgra_loader_pkg;

  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_NUM_SIDES = 4;
  localparam int DEF_PAD_W     = 16;
  localparam int DEF_CNT_W     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    MODE_CONST = 1'b0,
    MODE_INC   = 1'b1
  } mode_t;

endpackage

// File: rtl/cgra_loader_fifo.sv
// Config word FIFO: power-of-two depth, registered occupancy and ready flag.
module cgra_loader_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_nxt;
  logic             do_push, do_pop;

  // ready is a registered view of the count, so a pop never unblocks a push in the same cycle
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CNT_ONE;
    else if (!do_push && do_pop) count_nxt = count - CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_nxt;
      ready <= (count_nxt != FULL_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/cgra_config_stream_loader.sv
// Streams queued config words onto the fabric, then drives pad stimulus for a run window.
// Define CGRA_LOADER_CAPTURE_EN to accumulate a rotate/XOR signature of pad_obs_in during RUN.
module cgra_config_stream_loader
  import cgra_loader_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int NUM_SIDES = DEF_NUM_SIDES,
  parameter int PAD_W     = DEF_PAD_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                       clk_in,
  input  logic                       reset_n_in,
  input  logic                       start_in,
  input  logic                       mode_in,
  input  logic [PAD_W-1:0]           stim_base_in,
  input  logic [CNT_W-1:0]           run_cycles_in,
  input  logic                       cfg_valid_in,
  output logic                       cfg_ready_out,
  input  logic [ADDR_W-1:0]          cfg_addr_in,
  input  logic [DATA_W-1:0]          cfg_data_in,
  input  logic                       cfg_last_in,
  output logic [ADDR_W-1:0]          config_addr_out,
  output logic [DATA_W-1:0]          config_data_out,
  output logic [NUM_SIDES*PAD_W-1:0] pad_data_out,
  input  logic [PAD_W-1:0]           pad_obs_in,
  output logic                       busy_out,
  output logic                       config_done_out,
  output logic                       run_done_out,
  output logic [CNT_W-1:0]           cycle_count_out,
  output logic [PAD_W-1:0]           signature_out
);

  localparam int WORD_W = ADDR_W + DATA_W + 1;

  state_t                          state, state_nxt;
  logic                            fifo_empty, pop, pop_last;
  logic [WORD_W-1:0]               fifo_dout;
  logic [CNT_W-1:0]                cnt, run_last;
  logic [NUM_SIDES-1:0][PAD_W-1:0] pad_live, pad_hold;

  cgra_loader_fifo #(.WIDTH(WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst_n (reset_n_in),
    .push  (cfg_valid_in),
    .din   ({cfg_last_in, cfg_addr_in, cfg_data_in}),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .ready (cfg_ready_out)
  );

  assign pop      = (state == LOAD) && !fifo_empty;
  assign pop_last = fifo_dout[WORD_W-1];
  // a zero run length still runs for one cycle
  assign run_last = (run_cycles_in == '0) ? '0 : run_cycles_in - CNT_W'(1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = LOAD;
      LOAD:    if (pop && pop_last) state_nxt = RUN;
      RUN:     if (cnt == run_last) state_nxt = DONE;
      DONE:    if (start_in) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state           <= IDLE;
      config_addr_out <= '0;
      config_data_out <= '0;
      cnt             <= '0;
      pad_hold        <= '0;
    end else begin
      state <= state_nxt;
      if (pop) begin
        config_addr_out <= fifo_dout[ADDR_W+DATA_W-1:DATA_W];
        config_data_out <= fifo_dout[DATA_W-1:0];
      end else begin
        config_addr_out <= '0;
        config_data_out <= '0;
      end
      case (state)
        RUN: begin
          pad_hold <= pad_live;
          if (state_nxt == RUN) cnt <= cnt + CNT_W'(1);
        end
        DONE:    if (state_nxt == LOAD) cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_SIDES; k++) begin : g_side
    assign pad_live[k] = (mode_in == MODE_INC)
                       ? stim_base_in + PAD_W'(cnt) + PAD_W'(k)
                       : stim_base_in;
  end

  // DONE shows the last RUN-cycle stimulus captured in pad_hold
  assign pad_data_out    = (state == RUN)  ? pad_live :
                           (state == DONE) ? pad_hold : '0;
  assign cycle_count_out = cnt;
  assign busy_out        = (state == LOAD) || (state == RUN);
  assign config_done_out = (state == RUN) || (state == DONE);
  assign run_done_out    = (state == DONE);

`ifdef CGRA_LOADER_CAPTURE_EN
  logic [PAD_W-1:0] sig;

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in)
      sig <= '0;
    else if (state == RUN)
      sig <= {sig[PAD_W-2:0], sig[PAD_W-1]} ^ pad_obs_in;
    else if (state_nxt == RUN)
      sig <= '0;
  end

  assign signature_out = sig;
`else
  logic unused_obs;
  assign unused_obs    = ^pad_obs_in;
  assign signature_out = '0;
`endif

endmodule

// File: tb/tb_cgra_config_stream_loader.sv
// Randomized self-checking bench for cgra_config_stream_loader with a queue-based reference model.
// Signature expectations follow CGRA_LOADER_CAPTURE_EN when it is defined for the build.
module tb_cgra_config_stream_loader;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 8;
  localparam int NUM_SIDES = 4;
  localparam int PAD_W     = 16;
  localparam int CNT_W     = 32;
  localparam int WORD_W    = ADDR_W + DATA_W + 1;

  logic                       clk_in = 1'b0;
  logic                       reset_n_in = 1'b1;
  logic                       start_in = 1'b0;
  logic                       mode_in = 1'b0;
  logic [PAD_W-1:0]           stim_base_in = '0;
  logic [CNT_W-1:0]           run_cycles_in = '0;
  logic                       cfg_valid_in = 1'b0;
  logic                       cfg_ready_out;
  logic [ADDR_W-1:0]          cfg_addr_in = '0;
  logic [DATA_W-1:0]          cfg_data_in = '0;
  logic                       cfg_last_in = 1'b0;
  logic [ADDR_W-1:0]          config_addr_out;
  logic [DATA_W-1:0]          config_data_out;
  logic [NUM_SIDES*PAD_W-1:0] pad_data_out;
  logic [PAD_W-1:0]           pad_obs_in = '0;
  logic                       busy_out, config_done_out, run_done_out;
  logic [CNT_W-1:0]           cycle_count_out;
  logic [PAD_W-1:0]           signature_out;

  int total = 0;
  int bad   = 0;
  logic [WORD_W-1:0] exp_q[$];

  always #5 clk_in = ~clk_in;

  cgra_config_stream_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .NUM_SIDES(NUM_SIDES), .PAD_W(PAD_W), .CNT_W(CNT_W)
  ) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .start_in(start_in), .mode_in(mode_in),
    .stim_base_in(stim_base_in), .run_cycles_in(run_cycles_in),
    .cfg_valid_in(cfg_valid_in), .cfg_ready_out(cfg_ready_out),
    .cfg_addr_in(cfg_addr_in), .cfg_data_in(cfg_data_in), .cfg_last_in(cfg_last_in),
    .config_addr_out(config_addr_out), .config_data_out(config_data_out),
    .pad_data_out(pad_data_out), .pad_obs_in(pad_obs_in),
    .busy_out(busy_out), .config_done_out(config_done_out), .run_done_out(run_done_out),
    .cycle_count_out(cycle_count_out), .signature_out(signature_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [PAD_W-1:0] rotl1(input logic [PAD_W-1:0] v);
    return {v[PAD_W-2:0], v[PAD_W-1]};
  endfunction

  task automatic push_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic l);
    int w = 0;
    cfg_valid_in = 1'b1; cfg_addr_in = a; cfg_data_in = d; cfg_last_in = l;
    while (cfg_ready_out !== 1'b1 && w < 50) begin step(); w++; end
    total++;
    if (cfg_ready_out !== 1'b1) begin
      bad++; $display("FAIL push_ready got=%b want=1", cfg_ready_out);
    end else begin
      step();
      exp_q.push_back({l, a, d});
    end
    cfg_valid_in = 1'b0; cfg_last_in = 1'b0;
  endtask

  // Start a load and check every issued word against the queue until RUN is reached.
  // With pend set, one extra word is offered while the FIFO is full and must wait for the first pop.
  task automatic load_phase(input bit pend, input logic [WORD_W-1:0] pw);
    int issued = 0, cycles = 0;
    bit got_last = 0, pend_v = pend, acc;
    logic [WORD_W-1:0] e;
    start_in = 1'b1; step(); start_in = 1'b0;
    total++;
    if (busy_out !== 1'b1 || config_done_out !== 1'b0 || run_done_out !== 1'b0 || cycle_count_out !== '0) begin
      bad++; $display("FAIL load_entry busy=%b cdone=%b rdone=%b cnt=%0d want 1/0/0/0",
                      busy_out, config_done_out, run_done_out, cycle_count_out);
    end
    forever begin
      if (pend_v) begin
        cfg_valid_in = 1'b1; {cfg_last_in, cfg_addr_in, cfg_data_in} = pw;
      end
      if (config_addr_out !== '0 || config_data_out !== '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL issue_extra got=%h/%h want none", config_addr_out, config_data_out);
        end else begin
          e = exp_q.pop_front();
          if ({config_addr_out, config_data_out} !== e[WORD_W-2:0]) begin
            bad++; $display("FAIL issue_word got=%h/%h want=%h/%h", config_addr_out, config_data_out,
                            e[WORD_W-2:DATA_W], e[DATA_W-1:0]);
          end
          if (e[WORD_W-1]) got_last = 1;
        end
        if (pend && issued == 0) begin
          total++;
          if (cfg_ready_out !== 1'b1) begin bad++; $display("FAIL ready_after_pop got=%b want=1", cfg_ready_out); end
        end
        issued++;
      end else if (pend && issued == 0) begin
        total++;
        if (cfg_ready_out !== 1'b0) begin bad++; $display("FAIL ready_full got=%b want=0", cfg_ready_out); end
      end
      if (config_done_out === 1'b1) break;
      acc = pend_v && cfg_ready_out;
      step(); cycles++;
      if (acc) begin
        pend_v = 0; cfg_valid_in = 1'b0; cfg_last_in = 1'b0; exp_q.push_back(pw);
      end
      if (cycles > 100) begin
        total++; bad++; $display("FAIL load_timeout cycles=%0d want<=100", cycles);
        break;
      end
    end
    cfg_valid_in = 1'b0;
    total++;
    if (!got_last) begin bad++; $display("FAIL last_word got=0 want=1"); end
    total++;
    if (cycles !== issued) begin bad++; $display("FAIL load_gap cycles=%0d want=%0d", cycles, issued); end
  endtask

  // Walk RUN cycle by cycle against the arithmetic pad/count/signature model, then check DONE holds.
  task automatic run_phase(input bit mode, input logic [PAD_W-1:0] base, input int rc, input bit obs_one);
    int n = (rc == 0) ? 1 : rc;
    logic [PAD_W-1:0] sig_m = '0, exp_sig, ep, obs;
    logic [NUM_SIDES*PAD_W-1:0] last_pads = '0;
    for (int i = 0; i < n; i++) begin
`ifdef CGRA_LOADER_CAPTURE_EN
      exp_sig = sig_m;
`else
      exp_sig = '0;
`endif
      total++;
      if (busy_out !== 1'b1 || config_done_out !== 1'b1 || run_done_out !== 1'b0) begin
        bad++; $display("FAIL run_flags i=%0d busy=%b cdone=%b rdone=%b want 1/1/0", i, busy_out, config_done_out, run_done_out);
      end
      total++;
      if (cycle_count_out !== CNT_W'(i)) begin bad++; $display("FAIL run_count got=%0d want=%0d", cycle_count_out, i); end
      for (int k = 0; k < NUM_SIDES; k++) begin
        ep = mode ? PAD_W'(base + PAD_W'(i) + PAD_W'(k)) : base;
        last_pads[k*PAD_W +: PAD_W] = ep;
        total++;
        if (pad_data_out[k*PAD_W +: PAD_W] !== ep) begin
          bad++; $display("FAIL pad i=%0d side=%0d got=%0h want=%0h", i, k, pad_data_out[k*PAD_W +: PAD_W], ep);
        end
      end
      total++;
      if (signature_out !== exp_sig) begin bad++; $display("FAIL sig_run i=%0d got=%h want=%h", i, signature_out, exp_sig); end
      if (i > 0) begin
        total++;
        if (config_addr_out !== '0 || config_data_out !== '0) begin
          bad++; $display("FAIL cfg_idle_run got=%h/%h want=0/0", config_addr_out, config_data_out);
        end
      end
      obs = obs_one ? PAD_W'(1) : PAD_W'($urandom);
      pad_obs_in = obs;
      sig_m = rotl1(sig_m) ^ obs;
      start_in = 1'($urandom_range(0, 1));
      step();
    end
    start_in = 1'b0;
`ifdef CGRA_LOADER_CAPTURE_EN
    exp_sig = sig_m;
`else
    exp_sig = '0;
`endif
    for (int h = 0; h < 2; h++) begin
      total++;
      if (run_done_out !== 1'b1 || busy_out !== 1'b0 || config_done_out !== 1'b1) begin
        bad++; $display("FAIL done_flags h=%0d rdone=%b busy=%b cdone=%b want 1/0/1", h, run_done_out, busy_out, config_done_out);
      end
      total++;
      if (cycle_count_out !== CNT_W'(n - 1)) begin bad++; $display("FAIL done_count got=%0d want=%0d", cycle_count_out, n - 1); end
      total++;
      if (pad_data_out !== last_pads) begin bad++; $display("FAIL done_pads got=%h want=%h", pad_data_out, last_pads); end
      total++;
      if (signature_out !== exp_sig) begin bad++; $display("FAIL done_sig got=%h want=%h", signature_out, exp_sig); end
      pad_obs_in = PAD_W'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    #2 reset_n_in = 1'b0;
    #1;
    total++;
    if ({cfg_ready_out, busy_out, config_done_out, run_done_out} !== 4'b0 || config_addr_out !== '0 ||
        config_data_out !== '0 || pad_data_out !== '0 || cycle_count_out !== '0 || signature_out !== '0) begin
      bad++; $display("FAIL reset_outputs rdy=%b busy=%b addr=%h pads=%h cnt=%0d want all 0",
                      cfg_ready_out, busy_out, config_addr_out, pad_data_out, cycle_count_out);
    end
    repeat (3) step();
    total++;
    if (cfg_ready_out !== 1'b0) begin bad++; $display("FAIL reset_ready_held got=%b want=0", cfg_ready_out); end
    @(negedge clk_in) reset_n_in = 1'b1;
    step();
    total++;
    if (cfg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++; $display("FAIL reset_release rdy=%b busy=%b want 1/0", cfg_ready_out, busy_out);
    end
  endtask

  task automatic test_basic_load();
    push_word(32'h10, 32'hA, 1'b0);
    push_word(32'h11, 32'hB, 1'b0);
    push_word(32'h12, 32'hC, 1'b1);
    mode_in = 1'b1; stim_base_in = 16'd3; run_cycles_in = 32'd4;
    load_phase(1'b0, '0);
    run_phase(1'b1, 16'd3, 4, 1'b1);
  endtask

  task automatic test_zero_run();
    push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b0);
    push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b1);
    mode_in = 1'b0; stim_base_in = 16'd3; run_cycles_in = '0;
    load_phase(1'b0, '0);
    run_phase(1'b0, 16'd3, 0, 1'b0);
  endtask

  task automatic test_fifo_full();
    logic [WORD_W-1:0] pw;
    for (int i = 0; i < DEPTH; i++) push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b0);
    total++;
    if (cfg_ready_out !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", cfg_ready_out); end
    pw = {1'b1, ADDR_W'($urandom) | ADDR_W'(1), DATA_W'($urandom)};
    mode_in = 1'b1; stim_base_in = PAD_W'($urandom); run_cycles_in = 32'd3;
    load_phase(1'b1, pw);
    run_phase(1'b1, stim_base_in, 3, 1'b0);
  endtask

  task automatic test_random();
    int nw, rc;
    bit m;
    logic [PAD_W-1:0] b;
    for (int it = 0; it < 5; it++) begin
      nw = $urandom_range(1, DEPTH);
      for (int w = 0; w < nw; w++) push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'(w == nw - 1));
      m = 1'($urandom_range(0, 1));
      b = PAD_W'($urandom);
      rc = $urandom_range(0, 6);
      mode_in = m; stim_base_in = b; run_cycles_in = CNT_W'(rc);
      load_phase(1'b0, '0);
      run_phase(m, b, rc, 1'b0);
    end
  endtask

  task automatic test_reset_mid_run();
    push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b1);
    push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b0);
    push_word(ADDR_W'($urandom) | 1, DATA_W'($urandom), 1'b0);
    mode_in = 1'b1; stim_base_in = PAD_W'($urandom) | 16'h100; run_cycles_in = 32'd20;
    load_phase(1'b0, '0);
    pad_obs_in = 16'h00ff;
    repeat (3) step();
    #2 reset_n_in = 1'b0;
    #1;
    total++;
    if ({cfg_ready_out, busy_out, config_done_out, run_done_out} !== 4'b0 || config_addr_out !== '0 ||
        config_data_out !== '0 || pad_data_out !== '0 || cycle_count_out !== '0 || signature_out !== '0) begin
      bad++; $display("FAIL midrun_reset rdy=%b busy=%b cdone=%b pads=%h cnt=%0d sig=%h want all 0",
                      cfg_ready_out, busy_out, config_done_out, pad_data_out, cycle_count_out, signature_out);
    end
    exp_q.delete();
    @(negedge clk_in) reset_n_in = 1'b1;
    step();
    total++;
    if (cfg_ready_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++; $display("FAIL midrun_release rdy=%b busy=%b want 1/0", cfg_ready_out, busy_out);
    end
    start_in = 1'b1; step(); start_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      total++;
      if (busy_out !== 1'b1 || config_done_out !== 1'b0 || config_addr_out !== '0 || config_data_out !== '0) begin
        bad++; $display("FAIL empty_load c=%0d busy=%b cdone=%b addr=%h data=%h want 1/0/0/0",
                        c, busy_out, config_done_out, config_addr_out, config_data_out);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_zero_run();
    test_fifo_full();
    test_random();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
